// File: rtl/aes_byte_frame_adapter.sv
// Byte-serial front end for a 128-bit AES core: takes a command byte plus a
// 16-byte block, loads the core, waits for it to finish, then streams 16 result bytes.
module aes_byte_frame_adapter #(
   parameter int START_TIMEOUT = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   in_data_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   output logic [7:0]   out_data_o,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic         aes_load_o,
   output logic         aes_dec_o,
   output logic [127:0] aes_data_o,
   input  logic [127:0] aes_data_i,
   input  logic         aes_busy_i,
   output logic         err_o,
   output logic         busy_o
);

   typedef enum logic [2:0] {
      S_CMD,
      S_RX,
      S_LOAD,
      S_WAIT_START,
      S_WAIT_DONE,
      S_TX
   } state_t;

   localparam logic [7:0] CMD_ENC = 8'h45;
   localparam logic [7:0] CMD_DEC = 8'h44;
   localparam logic [7:0] TMO     = 8'(START_TIMEOUT);

   state_t         state, state_d;
   logic [3:0]     rx_cnt;
   logic [3:0]     tx_cnt;
   logic [7:0]     tmo_cnt;
   logic [127:0]   tx_q;

   logic in_hs, out_hs, cmd_ok, bad_cmd, tmo_expire;

   assign in_hs      = in_valid_i & in_ready_o;
   assign out_hs     = out_valid_o & out_ready_i;
   assign cmd_ok     = (in_data_i == CMD_ENC) || (in_data_i == CMD_DEC);
   assign bad_cmd    = (state == S_CMD) && in_hs && !cmd_ok;
   assign tmo_expire = (state == S_WAIT_START) && !aes_busy_i && ((tmo_cnt + 8'd1) == TMO);

   // Output byte is the top of the TX shift register; it only moves on a
   // handshake, so it stays put while the sink stalls.
   assign out_data_o = tx_q[127:120];

   always_comb begin
      state_d = state;
      case (state)
         S_CMD:        if (in_hs && cmd_ok) state_d = S_RX;
         S_RX:         if (in_hs && rx_cnt == 4'd15) state_d = S_LOAD;
         S_LOAD:       state_d = S_WAIT_START;
         S_WAIT_START: begin
            if (aes_busy_i)      state_d = S_WAIT_DONE;
            else if (tmo_expire) state_d = S_CMD;
         end
         S_WAIT_DONE:  if (!aes_busy_i) state_d = S_TX;
         S_TX:         if (out_hs && tx_cnt == 4'd15) state_d = S_CMD;
         default:      state_d = S_CMD;
      endcase
   end

   // Handshake/strobe outputs are registered from the next state so that no
   // output depends combinationally on in_valid_i or out_ready_i.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_CMD;
         in_ready_o  <= 1'b0;
         out_valid_o <= 1'b0;
         aes_load_o  <= 1'b0;
         aes_dec_o   <= 1'b0;
         aes_data_o  <= '0;
         err_o       <= 1'b0;
         busy_o      <= 1'b0;
         rx_cnt      <= '0;
         tx_cnt      <= '0;
         tmo_cnt     <= '0;
         tx_q        <= '0;
      end else begin
         state       <= state_d;
         in_ready_o  <= (state_d == S_CMD) || (state_d == S_RX);
         busy_o      <= (state_d != S_CMD);
         aes_load_o  <= (state_d == S_LOAD);
         out_valid_o <= (state_d == S_TX);
         err_o       <= bad_cmd || tmo_expire;
         case (state)
            S_CMD: begin
               if (in_hs && in_data_i == CMD_ENC) aes_dec_o <= 1'b0;
               if (in_hs && in_data_i == CMD_DEC) aes_dec_o <= 1'b1;
            end
            S_RX: begin
               if (in_hs) begin
                  aes_data_o <= {aes_data_o[119:0], in_data_i};
                  rx_cnt     <= rx_cnt + 4'd1;
               end
            end
            S_LOAD: tmo_cnt <= '0;
            S_WAIT_START: begin
               if (!aes_busy_i) tmo_cnt <= tmo_cnt + 8'd1;
            end
            S_WAIT_DONE: begin
               if (!aes_busy_i) begin
                  tx_q   <= aes_data_i;
                  tx_cnt <= '0;
               end
            end
            S_TX: begin
               if (out_hs) begin
                  tx_q   <= {tx_q[119:0], 8'h00};
                  tx_cnt <= tx_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_byte_frame_adapter.sv
// Directed bench for aes_byte_frame_adapter with a stub AES core and a frame-level
// reference model compared against the DUT every cycle.
module tb_aes_byte_frame_adapter;

   localparam int TMO = 8;
   localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   in_data_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [7:0]   out_data_o;
   logic         out_valid_o;
   logic         out_ready_i;
   logic         aes_load_o;
   logic         aes_dec_o;
   logic [127:0] aes_data_o;
   logic [127:0] aes_data_i;
   logic         aes_busy_i;
   logic         err_o;
   logic         busy_o;

   always #5 clk = ~clk;

   aes_byte_frame_adapter #(.START_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .aes_load_o(aes_load_o), .aes_dec_o(aes_dec_o), .aes_data_o(aes_data_o),
      .aes_data_i(aes_data_i), .aes_busy_i(aes_busy_i),
      .err_o(err_o), .busy_o(busy_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // Stub core: known-answer pair for the FIPS-197 key, otherwise bitwise invert.
   function automatic logic [127:0] stub_fn(input logic [127:0] b, input logic d);
      if (!d && b == PT) return CT;
      if (d && b == CT)  return PT;
      return ~b;
   endfunction

   // ---------------- reference model state ----------------
   int           pos;          // -1: expecting command, else data bytes received
   logic [127:0] m_blk;
   logic         m_dec;
   bit           inflight, load_exp, err_bad, ov_due, busy_prev, stall_prev;
   logic [7:0]   prev_data;
   int           cd;
   bit           skip_rdy;
   logic [7:0]   exp_q[$];
   logic [7:0]   got_q[$];
   int           load_cnt, err_cnt;
   logic [127:0] last_blk;
   logic         last_dec;
   bit           nobusy, rand_rdy;

   task automatic model_clear();
      pos = -1; m_blk = '0; m_dec = 1'b0;
      inflight = 0; load_exp = 0; err_bad = 0; ov_due = 0;
      busy_prev = 0; stall_prev = 0; prev_data = 8'h00; cd = 0;
      exp_q.delete();
   endtask

   function automatic logic [127:0] got_blk();
      logic [127:0] r = '0;
      for (int i = 0; i < 16; i++)
         r = {r[119:0], (i < got_q.size()) ? got_q[i] : 8'h00};
      return r;
   endfunction

   initial model_clear();

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_in_ready",  128'(in_ready_o),  128'd0);
         chk("rst_out_valid", 128'(out_valid_o), 128'd0);
         chk("rst_out_data",  128'(out_data_o),  128'd0);
         chk("rst_load",      128'(aes_load_o),  128'd0);
         chk("rst_dec",       128'(aes_dec_o),   128'd0);
         chk("rst_data",      aes_data_o,        128'd0);
         chk("rst_err",       128'(err_o),       128'd0);
         chk("rst_busy",      128'(busy_o),      128'd0);
         model_clear();
         skip_rdy = 1;
      end else begin : cmp
         bit load_now;
         chk("load", 128'(aes_load_o), 128'(load_exp));
         if (load_exp) begin
            chk("load_data", aes_data_o, m_blk);
            chk("load_dec", 128'(aes_dec_o), 128'(m_dec));
         end
         if (aes_load_o) begin
            load_cnt++; last_blk = aes_data_o; last_dec = aes_dec_o;
         end
         if (err_o) err_cnt++;
         chk("err", 128'(err_o), 128'(err_bad || cd == 1));
         if (skip_rdy) skip_rdy = 0;
         else chk("in_ready", 128'(in_ready_o), 128'(!inflight));
         chk("busy", 128'(busy_o), 128'(inflight || pos >= 0));
         if (ov_due) chk("out_valid_latency", 128'(out_valid_o), 128'd1);
         if (stall_prev) begin
            chk("stall_valid", 128'(out_valid_o), 128'd1);
            chk("stall_data", 128'(out_data_o), 128'(prev_data));
         end
         if (out_valid_o) begin
            if (exp_q.size() == 0) chk("out_unexpected", 128'(out_valid_o), 128'd0);
            else begin
               chk("out_data", 128'(out_data_o), 128'(exp_q[0]));
               if (out_ready_i) begin
                  void'(exp_q.pop_front());
                  got_q.push_back(out_data_o);
                  if (exp_q.size() == 0) inflight = 0;
               end
            end
         end
         // advance model to next cycle
         load_now  = load_exp;
         load_exp  = 0;
         err_bad   = 0;
         ov_due    = inflight && !nobusy && busy_prev && !aes_busy_i;
         busy_prev = aes_busy_i;
         if (cd > 0) cd--;
         if (cd == 1) inflight = 0;
         if (load_now && nobusy) cd = TMO + 1;
         if (in_valid_i && in_ready_o) begin
            if (pos < 0) begin
               if (in_data_i == 8'h45 || in_data_i == 8'h44) begin
                  pos = 0; m_dec = (in_data_i == 8'h44);
               end else err_bad = 1;
            end else begin
               m_blk = {m_blk[119:0], in_data_i};
               pos++;
               if (pos == 16) begin
                  logic [127:0] r;
                  pos = -1; load_exp = 1; inflight = 1;
                  if (!nobusy) begin
                     r = stub_fn(m_blk, m_dec);
                     for (int i = 0; i < 16; i++) exp_q.push_back(r[127-8*i -: 8]);
                  end
               end
            end
         end
         stall_prev = out_valid_o && !out_ready_i;
         prev_data  = out_data_o;
      end
   end

   // ---------------- stub core ----------------
   initial begin : stub
      logic [127:0] blk;
      logic         d;
      aes_busy_i = 1'b0;
      aes_data_i = '0;
      forever begin
         @(negedge clk);
         if (rst_n && aes_load_o && !nobusy) begin
            blk = aes_data_o; d = aes_dec_o;
            repeat (1 + $urandom_range(2, 0)) @(posedge clk);
            #1 aes_busy_i = 1'b1;
            repeat (5) @(posedge clk);
            #1 aes_data_i = stub_fn(blk, d);
            aes_busy_i = 1'b0;
         end
      end
   end

   initial begin
      out_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1 out_ready_i = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
      end
   end

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] b, input int gapmax);
      int n = 0;
      if (gapmax > 0) begin
         in_valid_i = 1'b0;
         repeat ($urandom_range(gapmax, 0)) begin @(posedge clk); #1; end
      end
      in_data_i = b; in_valid_i = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready_o) break;
         n++;
         if (n > 200) begin fail("send_byte"); break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [127:0] blk, input int gap);
      send_byte(cmd, gap);
      for (int i = 0; i < 16; i++) send_byte(blk[127-8*i -: 8], gap);
      in_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((inflight || exp_q.size() != 0 || !in_ready_o || busy_o) && n < 3000) begin
         @(negedge clk); n++;
      end
      if (n >= 3000) fail("wait_idle");
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      logic [127:0] blk;
      logic [7:0]   cmd;
      rst_n = 1'b0; in_data_i = 8'h00; in_valid_i = 1'b0;
      nobusy = 0; rand_rdy = 0; load_cnt = 0; err_cnt = 0;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // stub core, encrypt 00..0f
      got_q.delete(); load_cnt = 0;
      send_frame(8'h45, 128'h000102030405060708090a0b0c0d0e0f, 0);
      wait_idle();
      chk("t1_loads", 128'(load_cnt), 128'd1);
      chk("t1_blk", last_blk, 128'h000102030405060708090a0b0c0d0e0f);
      chk("t1_dec", 128'(last_dec), 128'd0);
      chk("t1_nbytes", 128'(got_q.size()), 128'd16);
      chk("t1_first", 128'(got_q[0]), 128'hff);
      chk("t1_last", 128'(got_q[15]), 128'hf0);

      // known-answer encrypt then decrypt
      got_q.delete();
      send_frame(8'h45, PT, 0); wait_idle();
      chk("kat_enc", got_blk(), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      got_q.delete();
      send_frame(8'h44, CT, 0); wait_idle();
      chk("kat_dec", got_blk(), 128'h00112233445566778899aabbccddeeff);
      chk("kat_dec_flag", 128'(last_dec), 128'd1);

      // bad command byte, then a normal frame
      got_q.delete(); err_cnt = 0;
      send_byte(8'h41, 0);
      send_frame(8'h45, 128'hdeadbeef_00000000_ffffffff_12345678, 0);
      wait_idle();
      chk("badcmd_err", 128'(err_cnt), 128'd1);
      chk("badcmd_out", got_blk(), 128'h21524110_ffffffff_00000000_edcba987);

      // core never starts
      nobusy = 1; err_cnt = 0; load_cnt = 0; got_q.delete();
      send_frame(8'h45, PT, 0); wait_idle();
      chk("tmo_err", 128'(err_cnt), 128'd1);
      chk("tmo_loads", 128'(load_cnt), 128'd1);
      chk("tmo_nout", 128'(got_q.size()), 128'd0);
      chk("tmo_ready", 128'(in_ready_o), 128'd1);
      nobusy = 0;

      // random gaps on both streams
      rand_rdy = 1;
      for (int f = 0; f < 3; f++) begin
         blk = {$urandom, $urandom, $urandom, $urandom};
         cmd = (f == 1) ? 8'h44 : 8'h45;
         got_q.delete();
         send_frame(cmd, blk, 2); wait_idle();
         chk("rand_frame", got_blk(), ~blk);
      end
      rand_rdy = 0;

      // reset after 7 data bytes, then a fresh frame
      send_byte(8'h45, 0);
      for (int i = 0; i < 7; i++) send_byte(8'(i), 0);
      in_valid_i = 1'b0;
      @(posedge clk); #1 rst_n = 1'b0;
      #2;
      chk("midrst_busy", 128'(busy_o), 128'd0);
      chk("midrst_data", aes_data_o, 128'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      got_q.delete(); load_cnt = 0;
      send_frame(8'h45, PT, 0); wait_idle();
      chk("midrst_kat", got_blk(), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      chk("midrst_loads", 128'(load_cnt), 128'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
